latch_wr_sched: RTL and testbench
=================================

LATCH_WR_SCHED -- requirements
Module: latch_wr_sched

Interface
REQ-001 Parameter WIDTH, default 4: data width of each latch word.
REQ-002 Parameter NUM_LATCHES, default 4: number of D latches in the controlled bank; power of two, 2..16.
REQ-003 Parameter OPEN_CYCLES, default 2: cycles lat_en is held high per write; range 1..15.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high. Ports are clk and rst.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req  input  2  per-requester write request, level, held until ack.
REQ-008 addr0, addr1  input  log2(NUM_LATCHES)  target latch index per requester.
REQ-009 data0, data1  input  WIDTH  write data per requester.
REQ-010 ack  output  2  one-cycle write-complete pulse per requester.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 lat_d  output  WIDTH  shared data bus to all latch d inputs.
REQ-013 lat_en  output  NUM_LATCHES  per-latch gate (clk of the latch), one-hot or zero.
REQ-014 lat_q  input  NUM_LATCHES*WIDTH  latch q outputs, latch i at bits [i*WIDTH +: WIDTH].
REQ-015 wr_err  output  1  readback mismatch flag, valid with ack.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, OPEN, HOLD, DONE.
REQ-017 IDLE: at a rising edge with req != 0, grant one requester, register its addr/data, go to SETUP; else stay.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests, the requester holding priority wins; after any grant, priority moves to the other requester.
REQ-019 SETUP lasts 1 cycle: lat_d = captured data, lat_en = 0.
REQ-020 OPEN lasts exactly OPEN_CYCLES cycles: lat_en has only bit [captured addr] high, lat_d unchanged.
REQ-021 HOLD lasts 1 cycle: lat_en = 0, lat_d still held (hold time).
REQ-022 DONE lasts 1 cycle: ack[granted] = 1, other ack bit 0; next state IDLE.
REQ-023 Latency: ack asserted in cycle OPEN_CYCLES+3 after the granting edge (cycle 5 at default).
REQ-024 Changes on req/addr/data after grant SHALL be ignored until IDLE is re-entered.
REQ-025 A requester still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-026 lat_en SHALL be driven from a register; no combinational glitch path from inputs.
REQ-027 lat_d outside SETUP..HOLD SHALL hold its last value.

Reset
REQ-028 While rst high: state IDLE, lat_en = 0, ack = 0, busy = 0, wr_err = 0, lat_d = 0, priority = requester 0.
REQ-029 Reset mid-write SHALL abort immediately with no ack for the aborted transaction.

Configuration
REQ-030 Macro LATCH_WR_SCHED_READBACK_EN: when defined, during HOLD compare lat_q word [captured addr] to captured data; on mismatch, wr_err = 1 in DONE, else 0.
REQ-031 Without the macro, wr_err SHALL be constant 0 and lat_q ignored; timing unchanged.

Structure
REQ-032 Package latch_ctrl_pkg SHALL hold the state enum, the requester-count constant (2) and the default WIDTH/NUM_LATCHES/OPEN_CYCLES values.
REQ-033 Sub-module rr_arb2 SHALL implement the two-input round-robin grant and priority register.

Verification (WIDTH=4, NUM_LATCHES=4, OPEN_CYCLES=2, bench models 4 D latches on lat_d/lat_en)
REQ-034 req=01, addr0=2, data0=4'hA -> SETUP 1 cycle, lat_en=4'b0100 for 2 cycles, ack=01 in cycle 5, latch 2 holds 4'hA.
REQ-035 req=11 from reset, addr0=0/data0=4'h3, addr1=1/data1=4'hC -> requester 0 acked first, then requester 1 after next IDLE; latches 0/1 = 3/C.
REQ-036 req=11 held through 4 transactions -> ack sequence 01,10,01,10; lat_en never has 2 bits set.
REQ-037 rst asserted during OPEN -> lat_en=0 and busy=0 same cycle, no ack; first request after rst granted to requester 0.
REQ-038 data0 changed 4'h5->4'hF during OPEN -> latch stores 4'h5.
REQ-039 With LATCH_WR_SCHED_READBACK_EN, bench forces lat_q[addr] to 4'h0 for a write of 4'h9 -> wr_err=1 with ack; correct readback -> wr_err=0.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
// Shared types and defaults for the latch write scheduler.
package latch_ctrl_pkg;

  localparam int unsigned NUM_REQ         = 2;
  localparam int unsigned DEF_WIDTH       = 4;
  localparam int unsigned DEF_NUM_LATCHES = 4;
  localparam int unsigned DEF_OPEN_CYCLES = 2;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; priority flips to the loser after each taken grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic [1:0] gnt_c_o
);

  logic prio_q, prio_d;

  // Grant: the priority holder wins a tie, a lone requester always wins.
  always_comb begin
    gnt_c_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_c_o[prio_q] = 1'b1;
    end else begin
      gnt_c_o = req_i;
    end
    prio_d = prio_q;
    if (take_i) begin
      prio_d = gnt_c_o[0];
    end
  end

  // Priority register, requester 0 first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/latch_wr_sched.sv
// Write scheduler for a bank of D latches: setup, open window, hold, ack.
// Optional readback check enabled by LATCH_WR_SCHED_READBACK_EN.
module latch_wr_sched
  import latch_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned NUM_LATCHES = DEF_NUM_LATCHES,
  parameter int unsigned OPEN_CYCLES = DEF_OPEN_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [$clog2(NUM_LATCHES)-1:0]   addr0,
  input  logic [$clog2(NUM_LATCHES)-1:0]   addr1,
  input  logic [WIDTH-1:0]                 data0,
  input  logic [WIDTH-1:0]                 data1,
  output logic [NUM_REQ-1:0]               ack,
  output logic                             busy,
  output logic [WIDTH-1:0]                 lat_d,
  output logic [NUM_LATCHES-1:0]           lat_en,
  input  logic [NUM_LATCHES*WIDTH-1:0]     lat_q,
  output logic                             wr_err
);

  localparam int unsigned AW = $clog2(NUM_LATCHES);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   who_q, who_d;
  logic [WIDTH-1:0]       lat_d_q, lat_d_d;
  logic [NUM_LATCHES-1:0] lat_en_q, lat_en_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic                   wr_err_q, wr_err_d;
  logic [1:0]             gnt_c;
  logic                   take_c;
  logic                   mismatch_c;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .take_i  (take_c),
    .gnt_c_o (gnt_c)
  );

`ifdef LATCH_WR_SCHED_READBACK_EN
  // Readback of the targeted latch word against the data still driven on lat_d.
  always_comb begin
    mismatch_c = (lat_q[addr_q*WIDTH +: WIDTH] != lat_d_q);
  end
`else
  logic lat_q_unused;
  assign lat_q_unused = ^lat_q;

  // Readback disabled: never flag an error.
  always_comb begin
    mismatch_c = 1'b0;
  end
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    who_d    = who_q;
    lat_d_d  = lat_d_q;
    take_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          take_c  = 1'b1;
          who_d   = gnt_c[1];
          addr_d  = gnt_c[1] ? addr1 : addr0;
          lat_d_d = gnt_c[1] ? data1 : data0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = OPEN;
      end
      OPEN: begin
        if (cnt_q == CNT_W'(OPEN_CYCLES - 1)) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    lat_en_d = (state_d == OPEN) ? (NUM_LATCHES'(1) << addr_d) : '0;
    ack_d    = '0;
    if (state_d == DONE) begin
      ack_d[who_d] = 1'b1;
    end
    wr_err_d = (state_d == DONE) && mismatch_c;
  end

  // State and output registers; reset aborts any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      who_q    <= 1'b0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      who_q    <= who_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign ack    = ack_q;
  assign busy   = busy_q;
  assign lat_d  = lat_d_q;
  assign lat_en = lat_en_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_latch_wr_sched.sv
// Bench for latch_wr_sched: directed scenarios plus random traffic against a
// transaction-phase reference model driving four behavioural D latches.
module tb_latch_wr_sched;

  localparam int unsigned W  = 4;
  localparam int unsigned NL = 4;
  localparam int unsigned OC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [1:0]    addr0, addr1;
  logic [W-1:0]  data0, data1;
  logic [1:0]    ack;
  logic          busy;
  logic [W-1:0]  lat_d;
  logic [NL-1:0] lat_en;
  logic [NL*W-1:0] lat_q;
  logic          wr_err;

  logic          rb_force = 1'b0;
  logic [1:0]    rb_addr  = 2'd0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase counts cycles since the granting edge (0 = idle).
  int         m_phase;
  logic       m_prio;
  logic       m_who;
  logic [1:0] m_addr;
  logic [W-1:0] m_data;
  logic [W-1:0] m_latd;
  logic       m_err;

  logic [1:0] ack_log [$];

  always #5 clk = ~clk;

  latch_wr_sched #(.WIDTH(W), .NUM_LATCHES(NL), .OPEN_CYCLES(OC)) dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1), .ack(ack), .busy(busy), .lat_d(lat_d),
    .lat_en(lat_en), .lat_q(lat_q), .wr_err(wr_err)
  );

  // Behavioural latch bank, with an override that corrupts one readback word.
  for (genvar g = 0; g < NL; g++) begin : g_lat
    logic [W-1:0] q;
    always_latch begin
      if (lat_en[g]) q <= lat_d;
    end
    assign lat_q[g*W +: W] = (rb_force && rb_addr == 2'(g)) ? '0 : q;
  end

  function automatic logic [W-1:0] lw(input logic [1:0] a);
    return lat_q[a*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge, using the inputs the DUT sees there.
  task automatic model_edge();
    if (m_phase == OC + 3) begin
      m_phase = 0;
    end else if (m_phase != 0) begin
      if (m_phase == OC + 2) begin
`ifdef LATCH_WR_SCHED_READBACK_EN
        m_err = (lw(m_addr) != m_data);
`else
        m_err = 1'b0;
`endif
      end
      m_phase++;
    end
    else if (req != 2'b00) begin
      m_who   = (req == 2'b11) ? m_prio : req[1];
      m_addr  = m_who ? addr1 : addr0;
      m_data  = m_who ? data1 : data0;
      m_latd  = m_data;
      m_prio  = ~m_who;
      m_phase = 1;
    end
  endtask

  task automatic check_outputs();
    logic [NL-1:0] en_e;
    logic [1:0]    ack_e;
    en_e  = (m_phase >= 2 && m_phase <= OC + 1) ? (4'(1) << m_addr) : '0;
    ack_e = (m_phase == OC + 3) ? (m_who ? 2'b10 : 2'b01) : 2'b00;
    chk("busy",   32'(busy),   32'(m_phase != 0));
    chk("lat_en", 32'(lat_en), 32'(en_e));
    chk("ack",    32'(ack),    32'(ack_e));
    chk("lat_d",  32'(lat_d),  32'(m_latd));
    chk("wr_err", 32'(wr_err), 32'((m_phase == OC + 3) && m_err));
    chk("en_onehot", 32'($countones(lat_en) <= 1), 32'd1);
    if (m_phase == OC + 3 && !rb_force) chk("latch_word", 32'(lw(m_addr)), 32'(m_data));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    if (ack != 2'b00) ack_log.push_back(ack);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    m_phase = 0;
    m_prio  = 1'b0;
    m_latd  = '0;
    m_err   = 1'b0;
    #2;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic new_payload(input int r);
    if (r == 0) begin
      addr0 = 2'($urandom); data0 = 4'($urandom);
    end else begin
      addr1 = 2'($urandom); data1 = 4'($urandom);
    end
  endtask

  // Requesters hold req until acked, then drop or immediately re-request.
  task automatic drive_random();
    logic [1:0] ack_e;
    ack_e = (m_phase == OC + 3) ? (m_who ? 2'b10 : 2'b01) : 2'b00;
    for (int r = 0; r < 2; r++) begin
      if (ack_e[r]) begin
        if ($urandom_range(1, 0) == 0) req[r] = 1'b0;
        else new_payload(r);
      end else if (!req[r]) begin
        if ($urandom_range(2, 0) == 0) begin
          req[r] = 1'b1;
          new_payload(r);
        end
      end else if ($urandom_range(3, 0) == 0) begin
        new_payload(r);
      end
    end
  endtask

  initial begin
    req = 2'b00; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    do_reset();

    // Single write from requester 0: ack in cycle 5, latch 2 holds A.
    req = 2'b01; addr0 = 2'd2; data0 = 4'hA;
    for (int i = 0; i < 5; i++) step();
    chk("single_ack_c5", 32'(ack), 32'h1);
    chk("single_latch2", 32'(lw(2'd2)), 32'hA);
    req = 2'b00;
    step();

    // Simultaneous requests from reset: requester 0 first.
    do_reset();
    req = 2'b11; addr0 = 2'd0; data0 = 4'h3; addr1 = 2'd1; data1 = 4'hC;
    for (int i = 0; i < 5; i++) step();
    chk("rr_first", 32'(ack), 32'h1);
    req[0] = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("rr_second", 32'(ack), 32'h2);
    req[1] = 1'b0;
    chk("rr_latch0", 32'(lw(2'd0)), 32'h3);
    chk("rr_latch1", 32'(lw(2'd1)), 32'hC);
    step();

    // Both held through four transactions: strict alternation.
    do_reset();
    ack_log.delete();
    req = 2'b11; addr0 = 2'd3; data0 = 4'h1; addr1 = 2'd2; data1 = 4'h2;
    for (int i = 0; i < 24; i++) step();
    req = 2'b00;
    chk("alt_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      chk("alt_seq", 32'(ack_log[i]), (i % 2 == 0) ? 32'h1 : 32'h2);

    // Reset during the open window aborts; next tie goes to requester 0.
    do_reset();
    req = 2'b01; addr0 = 2'd3; data0 = 4'h6;
    step(); step();
    chk("pre_rst_open", 32'(lat_en), 32'h8);
    do_reset();
    req = 2'b11; addr0 = 2'd0; data0 = 4'h7; addr1 = 2'd1; data1 = 4'h8;
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_gnt0", 32'(ack), 32'h1);
    req = 2'b00;
    step();

    // Data change after grant is ignored.
    req = 2'b01; addr0 = 2'd1; data0 = 4'h5;
    step(); step();
    data0 = 4'hF;
    for (int i = 0; i < 3; i++) step();
    chk("late_change_latch", 32'(lw(2'd1)), 32'h5);
    req = 2'b00;
    step();

    // Corrupted readback, then a clean one.
    rb_force = 1'b1; rb_addr = 2'd2;
    req = 2'b01; addr0 = 2'd2; data0 = 4'h9;
    for (int i = 0; i < 5; i++) step();
`ifdef LATCH_WR_SCHED_READBACK_EN
    chk("rb_bad", 32'(wr_err), 32'd1);
`else
    chk("rb_bad", 32'(wr_err), 32'd0);
`endif
    req = 2'b00; rb_force = 1'b0;
    step();
    req = 2'b01;
    for (int i = 0; i < 5; i++) step();
    chk("rb_good", 32'(wr_err), 32'd0);
    req = 2'b00;
    step();

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      step();
      if ($urandom_range(119, 0) == 0) do_reset();
      drive_random();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
